wb_io_arbiter64: RTL and testbench

WB_IO_ARBITER64 -- requirements
Module: wb_io_arbiter64

---
 rtl/wishbone_pkg.sv | 43 ++++
 rtl/wb_rr_sel.sv | 29 ++
 rtl/wb_io_arbiter64.sv | 144 ++++++++++++++
 tb/tb_wb_io_arbiter64.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/wishbone_pkg.sv
// Wishbone 64-bit command request/response types, error codes and arbiter state enum.
// WB_IO_ARB_TIMEOUT_EN adds the ERR state used by the arbiter watchdog.
package wishbone_pkg;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    typedef struct packed {
        logic        cyc;
        logic        stb;
        logic        we;
        logic [7:0]  sel;
        logic [31:0] adr;
        logic [63:0] dat;
        logic [3:0]  cmd;
        logic [7:0]  tid;
        logic [1:0]  bte;
        logic [2:0]  cti;
    } wb_cmd_request64_t;

    typedef struct packed {
        logic        ack;
        logic [1:0]  err;
        logic [7:0]  tid;
        logic [63:0] dat;
    } wb_cmd_response64_t;

`ifdef WB_IO_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ERR} wb_arb_state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY} wb_arb_state_t;
`endif

    // Parked bus: nothing selected, address pointed at an unmapped location.
    function automatic wb_cmd_request64_t wb_idle_req();
        wb_cmd_request64_t r;
        r     = '0;
        r.adr = 32'hFFFF_FFFF;
        return r;
    endfunction

endpackage

// File: rtl/wb_rr_sel.sv
// Round-robin selector: first set request searching upward from last_gnt+1, wrapping.
module wb_rr_sel #(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_vec,
    input  logic [IW-1:0]   last_gnt,
    output logic [NREQ-1:0] gnt_oh,
    output logic [IW-1:0]   gnt_idx,
    output logic            any
);

    always_comb begin
        logic [IW-1:0] j;
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        j       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            j = IW'((int'(last_gnt) + k) % NREQ);
            if (!any && req_vec[j]) begin
                any        = 1'b1;
                gnt_idx    = j;
                gnt_oh[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_io_arbiter64.sv
// Round-robin, bus-locking arbiter of NREQ Wishbone masters onto one I/O bridge port.
// Define WB_IO_ARB_TIMEOUT_EN to add the no-ack watchdog that answers with DECERR.
module wb_io_arbiter64
    import wishbone_pkg::*;
#(
    parameter int         NREQ    = 4,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  wb_cmd_request64_t  req [NREQ],
    output wb_cmd_response64_t resp [NREQ],
    output wb_cmd_request64_t  m_req,
    input  wb_cmd_response64_t m_resp,
    output logic [NREQ-1:0]    gnt_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT == 8'd0) begin : g_param_chk
        $error("wb_io_arbiter64: NREQ must be 2..8 and TIMEOUT nonzero");
    end

    wb_arb_state_t     state, state_d;
    logic [IW-1:0]     gidx, gidx_d, last_gnt, last_d;
    logic [NREQ-1:0]   gnt_d, cyc_vec, sel_oh;
    logic [IW-1:0]     sel_idx;
    logic              sel_any;
    wb_cmd_request64_t mreq_d;
`ifdef WB_IO_ARB_TIMEOUT_EN
    logic [7:0]        cnt, cnt_d, cnt_inc;
    logic              err_first, err_first_d;
`endif

    always_comb begin
        for (int i = 0; i < NREQ; i++) cyc_vec[i] = req[i].cyc;
    end

    wb_rr_sel #(.NREQ(NREQ), .IW(IW)) u_sel (
        .req_vec  (cyc_vec),
        .last_gnt (last_gnt),
        .gnt_oh   (sel_oh),
        .gnt_idx  (sel_idx),
        .any      (sel_any)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            gidx      <= '0;
            last_gnt  <= IW'(NREQ - 1);
            gnt_o     <= '0;
            m_req     <= wb_idle_req();
`ifdef WB_IO_ARB_TIMEOUT_EN
            cnt       <= '0;
            err_first <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            gidx      <= gidx_d;
            last_gnt  <= last_d;
            gnt_o     <= gnt_d;
            m_req     <= mreq_d;
`ifdef WB_IO_ARB_TIMEOUT_EN
            cnt       <= cnt_d;
            err_first <= err_first_d;
`endif
        end
    end

    // m_req defaults to idle, so the release edge and the grant edge both park the bus.
    always_comb begin
        state_d = state;
        gidx_d  = gidx;
        last_d  = last_gnt;
        gnt_d   = gnt_o;
        mreq_d  = wb_idle_req();
`ifdef WB_IO_ARB_TIMEOUT_EN
        cnt_d       = cnt;
        cnt_inc     = cnt + 8'd1;
        err_first_d = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (sel_any) begin
                    state_d = BUSY;
                    gidx_d  = sel_idx;
                    gnt_d   = sel_oh;
`ifdef WB_IO_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            BUSY: begin
                if (!req[gidx].cyc) begin
                    state_d = IDLE;
                    last_d  = gidx;
                    gnt_d   = '0;
                end else begin
                    mreq_d = req[gidx];
`ifdef WB_IO_ARB_TIMEOUT_EN
                    if (m_resp.ack) begin
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == TIMEOUT) begin
                            state_d     = ERR;
                            mreq_d      = wb_idle_req();
                            err_first_d = 1'b1;
                        end
                    end
`endif
                end
            end
`ifdef WB_IO_ARB_TIMEOUT_EN
            ERR: begin
                if (!req[gidx].cyc) begin
                    state_d = IDLE;
                    last_d  = gidx;
                    gnt_d   = '0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            resp[i] = '0;
            if (gidx == IW'(i)) begin
                if (state == BUSY) resp[i] = m_resp;
`ifdef WB_IO_ARB_TIMEOUT_EN
                if (state == ERR && err_first) begin
                    resp[i].ack = 1'b1;
                    resp[i].err = DECERR;
                    resp[i].tid = req[i].tid;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_wb_io_arbiter64.sv
// Directed bench for wb_io_arbiter64 (NREQ=4, TIMEOUT=16).
module tb_wb_io_arbiter64;
    import wishbone_pkg::*;

    logic               clk_i = 1'b0;
    logic               rst_i;
    wb_cmd_request64_t  req [4];
    wb_cmd_response64_t resp [4];
    wb_cmd_request64_t  m_req;
    wb_cmd_response64_t m_resp;
    logic [3:0]         gnt_o;

    int n_chk  = 0;
    int n_fail = 0;

    wb_io_arbiter64 #(.NREQ(4), .TIMEOUT(8'd16)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req    (req),
        .resp   (resp),
        .m_req  (m_req),
        .m_resp (m_resp),
        .gnt_o  (gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_resp_zero(input string tag);
        for (int i = 0; i < 4; i++) chk(tag, 128'(resp[i]), 128'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) req[i] = '0;
        m_resp = '0;
        rst_i  = 1'b1;
        tick();
        tick();
        chk("rst_gnt", 128'(gnt_o), 128'd0);
        chk("rst_madr", 128'(m_req.adr), 128'hFFFF_FFFF);
        chk("rst_mcyc", 128'(m_req.cyc), 128'd0);
        chk_resp_zero("rst_resp");
        rst_i = 1'b0;

        // req0 and req2 together: 0 first, idle gap, then 2
        req[0].cyc = 1'b1; req[0].stb = 1'b1;
        req[2].cyc = 1'b1; req[2].stb = 1'b1;
        tick();
        chk("g0_gnt", 128'(gnt_o), 128'b0001);
        chk("g0_idle_mreq", 128'(m_req.cyc), 128'd0);
        tick();
        chk("g0_mcyc", 128'(m_req.cyc), 128'd1);
        req[0] = '0;
        tick();
        chk("rel0_gnt", 128'(gnt_o), 128'd0);
        chk("rel0_madr", 128'(m_req.adr), 128'hFFFF_FFFF);
        tick();
        chk("g2_gnt", 128'(gnt_o), 128'b0100);
        chk("g2_gap_mcyc", 128'(m_req.cyc), 128'd0);
        tick();
        chk("g2_mcyc", 128'(m_req.cyc), 128'd1);
        req[2] = '0;
        tick();
        chk("rel2_gnt", 128'(gnt_o), 128'd0);
        tick();

        // req1 write; last_gnt=2 so search 3,0,1
        req[1].cyc = 1'b1; req[1].stb = 1'b1; req[1].we = 1'b1;
        req[1].sel = 8'hFF; req[1].adr = 32'hFFDC_0010;
        req[1].dat = 64'h1234; req[1].tid = 8'h05; req[1].cmd = 4'h3;
        tick();
        chk("g1_gnt", 128'(gnt_o), 128'b0010);
        tick();
        chk("w1_madr", 128'(m_req.adr), 128'hFFDC_0010);
        chk("w1_mdat", 128'(m_req.dat), 128'h1234);
        chk("w1_mwe", 128'(m_req.we), 128'd1);
        chk("w1_mtid", 128'(m_req.tid), 128'h05);
        chk("w1_mcmd", 128'(m_req.cmd), 128'h3);
        m_resp.ack = 1'b1; m_resp.tid = 8'h05; m_resp.dat = 64'hBEEF;
        #1;
        chk("w1_r1ack", 128'(resp[1].ack), 128'd1);
        chk("w1_r1dat", 128'(resp[1].dat), 128'hBEEF);
        chk("w1_r0", 128'(resp[0]), 128'd0);
        chk("w1_r2", 128'(resp[2]), 128'd0);
        chk("w1_r3", 128'(resp[3]), 128'd0);
        m_resp = '0;
        req[1] = '0;
        tick();
        chk("rel1_gnt", 128'(gnt_o), 128'd0);
        tick();

        // reset mid-BUSY with req3 pending; last_gnt=1 so req2 wins first
        req[2].cyc = 1'b1; req[2].stb = 1'b1; req[2].adr = 32'h0000_1000;
        req[3].cyc = 1'b1; req[3].stb = 1'b1;
        tick();
        chk("g2b_gnt", 128'(gnt_o), 128'b0100);
        tick();
        chk("g2b_madr", 128'(m_req.adr), 128'h1000);
        rst_i = 1'b1;
        req[2] = '0;
        m_resp.ack = 1'b1;
        tick();
        chk("mrst_madr", 128'(m_req.adr), 128'hFFFF_FFFF);
        chk("mrst_gnt", 128'(gnt_o), 128'd0);
        chk_resp_zero("mrst_resp");
        m_resp = '0;
        rst_i  = 1'b0;
        tick();
        chk("g3_gnt", 128'(gnt_o), 128'b1000);
        req[3] = '0;
        tick();
        chk("rel3_gnt", 128'(gnt_o), 128'd0);

        // ack while idle is not routed anywhere
        m_resp.ack = 1'b1; m_resp.err = SLVERR;
        #1;
        chk_resp_zero("idle_ack");
        m_resp = '0;
        tick();

        // reset to restart search at 0, then all four request continuously
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req[i].cyc = 1'b1; req[i].stb = 1'b1;
        end
        for (int n = 0; n < 5; n++) begin
            int e;
            e = n % 4;
            tick();
            chk($sformatf("rr%0d_gnt", n), 128'(gnt_o), 128'(4'b0001 << e));
            tick();
            m_resp.ack = 1'b1;
            #1;
            chk($sformatf("rr%0d_ack", n), 128'(resp[e].ack), 128'd1);
            m_resp = '0;
            req[e].cyc = 1'b0;
            tick();
            chk($sformatf("rr%0d_rel", n), 128'(gnt_o), 128'd0);
            req[e].cyc = 1'b1;
        end
        for (int i = 0; i < 4; i++) req[i] = '0;
        tick();
        tick();

`ifdef WB_IO_ARB_TIMEOUT_EN
        // last_gnt=0 after the round-robin run; req1 alone, never acked
        req[1].cyc = 1'b1; req[1].stb = 1'b1; req[1].tid = 8'h2A;
        tick();
        chk("to_gnt", 128'(gnt_o), 128'b0010);
        for (int c = 0; c < 15; c++) tick();
        chk("to_pre_ack", 128'(resp[1].ack), 128'd0);
        chk("to_pre_mcyc", 128'(m_req.cyc), 128'd1);
        tick();
        chk("to_ack", 128'(resp[1].ack), 128'd1);
        chk("to_err", 128'(resp[1].err), 128'(DECERR));
        chk("to_tid", 128'(resp[1].tid), 128'h2A);
        chk("to_mcyc", 128'(m_req.cyc), 128'd0);
        tick();
        chk("to_once", 128'(resp[1]), 128'd0);
        chk("to_hold", 128'(gnt_o), 128'b0010);
        req[1] = '0;
        tick();
        chk("to_rel", 128'(gnt_o), 128'd0);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
